// File: rtl/jpeg_bank_sched.sv
// Ping-pong bank scheduler between a word-writing producer (DMA) and a
// block consumer (DCT controller). Two input-BRAM banks each hold one
// 8x8 block of WPB words; a run moves cfg_nblocks_i blocks through them.
module jpeg_bank_sched #(
   parameter int WPB = 16
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     start_i,
   input  logic                     abort_i,
   input  logic [15:0]              cfg_nblocks_i,
   input  logic                     prod_wr_i,
   output logic                     prod_rdy_o,
   output logic                     wr_en_o,
   output logic [$clog2(WPB):0]     wr_adr_o,
   output logic                     cons_start_o,
   output logic                     cons_bank_o,
   input  logic                     cons_done_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o,
   output logic [15:0]              blk_cnt_o
);

   localparam int AW = $clog2(WPB);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [1:0]    full_q, full_d;
   logic          wbank_q, wbank_d;
   logic          rbank_q, rbank_d;
   logic [AW-1:0] wcnt_q, wcnt_d;
   logic          cbusy_q, cbusy_d;
   logic [15:0]   filled_q, filled_d;
   logic [15:0]   consumed_q, consumed_d;
   logic [15:0]   nblk_q, nblk_d;
   logic          err_q, err_d;
   logic          cons_start_q, cons_start_d;

   // Outputs are decoded straight from registered state (write path is zero latency)
   always_comb begin
      prod_rdy_o   = (state_q == RUN) & ~full_q[wbank_q] & (filled_q < nblk_q);
      wr_en_o      = prod_wr_i & prod_rdy_o;
      wr_adr_o     = {wbank_q, wcnt_q};
      cons_start_o = cons_start_q;
      cons_bank_o  = rbank_q;
      busy_o       = (state_q == RUN) | (state_q == DONE);
      done_o       = (state_q == DONE);
      err_o        = err_q;
      blk_cnt_o    = consumed_q;
   end

   // Next-state: run FSM, bank fill/drain bookkeeping, consumer handshake, error flag
   always_comb begin
      state_d      = state_q;
      full_d       = full_q;
      wbank_d      = wbank_q;
      rbank_d      = rbank_q;
      wcnt_d       = wcnt_q;
      cbusy_d      = cbusy_q;
      filled_d     = filled_q;
      consumed_d   = consumed_q;
      nblk_d       = nblk_q;
      err_d        = err_q;
      cons_start_d = 1'b0;

      if (abort_i) begin
         // Abort overrides everything; the error flag survives so software can see it
         state_d    = IDLE;
         full_d     = 2'b00;
         wbank_d    = 1'b0;
         rbank_d    = 1'b0;
         wcnt_d     = '0;
         cbusy_d    = 1'b0;
         filled_d   = '0;
         consumed_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  nblk_d     = cfg_nblocks_i;
                  full_d     = 2'b00;
                  wbank_d    = 1'b0;
                  rbank_d    = 1'b0;
                  wcnt_d     = '0;
                  cbusy_d    = 1'b0;
                  filled_d   = '0;
                  consumed_d = '0;
                  err_d      = 1'b0;
                  state_d    = (cfg_nblocks_i == 16'd0) ? DONE : RUN;
               end
            end
            RUN:     if (consumed_q == nblk_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase

         // Producer side: last word of a block seals the bank and flips the write pointer
         if (wr_en_o) begin
            if (wcnt_q == AW'(WPB - 1)) begin
               wcnt_d          = '0;
               full_d[wbank_q] = 1'b1;
               wbank_d         = ~wbank_q;
               filled_d        = filled_q + 16'd1;
            end else begin
               wcnt_d = wcnt_q + AW'(1);
            end
         end

         // Consumer side: the filling bank is never full, so this never touches the same flag
         if (cons_done_i && cbusy_q) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = ~rbank_q;
            cbusy_d         = 1'b0;
            consumed_d      = consumed_q + 16'd1;
         end

         // Launch the consumer on a full bank; busy blocks a relaunch until done returns
         if ((state_q == RUN) && !cbusy_q && full_q[rbank_q]) begin
            cons_start_d = 1'b1;
            cbusy_d      = 1'b1;
         end

         if ((prod_wr_i && !prod_rdy_o) || (cons_done_i && !cbusy_q))
            err_d = 1'b1;
      end
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q      <= IDLE;
         full_q       <= 2'b00;
         wbank_q      <= 1'b0;
         rbank_q      <= 1'b0;
         wcnt_q       <= '0;
         cbusy_q      <= 1'b0;
         filled_q     <= '0;
         consumed_q   <= '0;
         nblk_q       <= '0;
         err_q        <= 1'b0;
         cons_start_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         full_q       <= full_d;
         wbank_q      <= wbank_d;
         rbank_q      <= rbank_d;
         wcnt_q       <= wcnt_d;
         cbusy_q      <= cbusy_d;
         filled_q     <= filled_d;
         consumed_q   <= consumed_d;
         nblk_q       <= nblk_d;
         err_q        <= err_d;
         cons_start_q <= cons_start_d;
      end
   end

endmodule

// File: doc/jpeg_bank_sched.md
JPEG_BANK_SCHED -- requirements
Module: jpeg_bank_sched

Interface
REQ-001 SHALL have parameter WPB, default 16, words per 8x8 block (4 pixels per 32-bit word); legal values are powers of two, 4..64.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rstn_i, input, 1, synchronous active-low reset.
REQ-004 SHALL have port start_i, input, 1, one-cycle pulse that starts a run of cfg_nblocks_i blocks.
REQ-005 SHALL have port abort_i, input, 1, cancels the run.
REQ-006 SHALL have port cfg_nblocks_i, input, 16, number of blocks in the run, sampled on start_i.
REQ-007 SHALL have port prod_wr_i, input, 1, producer (DMA) word-write strobe.
REQ-008 SHALL have port prod_rdy_o, output, 1, a free bank can accept words.
REQ-009 SHALL have port wr_en_o, output, 1, input BRAM write enable.
REQ-010 SHALL have port wr_adr_o, output, log2(WPB)+1, input BRAM address {wbank, wcnt}.
REQ-011 SHALL have port cons_start_o, output, 1, one-cycle pulse telling the DCT controller to process bank cons_bank_o.
REQ-012 SHALL have port cons_bank_o, output, 1, bank being consumed.
REQ-013 SHALL have port cons_done_i, input, 1, pulse from the DCT controller that the current bank is finished.
REQ-014 SHALL have ports busy_o (1) and done_o (1, one-cycle pulse at end of run), both outputs.
REQ-015 SHALL have ports err_o (1, sticky protocol error) and blk_cnt_o (16, blocks consumed this run), both outputs.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE: IDLE->RUN on start_i with cfg_nblocks_i!=0; IDLE->DONE on start_i with cfg_nblocks_i==0; RUN->DONE when the consumed count equals N; DONE->IDLE unconditionally after one cycle.
REQ-017 SHALL assert done_o exactly during the DONE cycle and assert busy_o in RUN and DONE.
REQ-018 SHALL ignore start_i outside IDLE.
REQ-019 SHALL keep two banks, each with a registered full flag; a write pointer wbank, a read pointer rbank, a word counter wcnt, a consumer-busy flag, and 16-bit filled and consumed block counters.
REQ-020 SHALL drive prod_rdy_o = RUN & !full[wbank] & (filled < N), combinationally from registered state.
REQ-021 SHALL drive wr_en_o = prod_wr_i & prod_rdy_o, with wr_adr_o = {wbank, wcnt} in the same cycle (zero latency).
REQ-022 SHALL increment wcnt on each accepted word; on the WPB-th word it SHALL wrap wcnt to 0, set full[wbank], toggle wbank and increment filled, all on that edge.
REQ-023 SHALL register cons_start_o high for one cycle, and set consumer-busy on the same edge, when RUN & !busy & full[rbank]; the earliest start is therefore the cycle after full is set.
REQ-024 SHALL drive cons_bank_o = rbank, stable from cons_start_o until the cons_done_i edge.
REQ-025 SHALL, on cons_done_i while consumer-busy, clear full[rbank], toggle rbank, clear busy and increment consumed/blk_cnt_o; the next cons_start_o is issued no earlier than 2 cycles after cons_done_i.
REQ-026 SHALL apply a bank-fill completion and a cons_done_i in the same cycle both, independently.
REQ-027 SHALL never let the producer write a bank whose full flag is set; with both banks full, prod_rdy_o stays 0.
REQ-028 SHALL set err_o on prod_wr_i while !prod_rdy_o (write dropped) or on cons_done_i while not consumer-busy (pulse ignored); err_o clears only on accepted start_i or reset.
REQ-029 SHALL, on abort_i (priority over every input except rstn_i), clear full flags, pointers, wcnt, busy and counters and go to IDLE next cycle without pulsing done_o; blk_cnt_o reads 0 afterwards.
REQ-030 SHALL, on accepted start_i, clear blk_cnt_o, the counters, pointers and err_o.

Reset
REQ-031 SHALL, with rstn_i low at a clock edge, force state IDLE, all flags, pointers and counters to 0, and all outputs (prod_rdy_o, wr_en_o, wr_adr_o, cons_start_o, cons_bank_o, busy_o, done_o, err_o, blk_cnt_o) to 0 from the next cycle, including mid-run.
REQ-032 SHALL give reset priority over start_i and abort_i.

Verification
REQ-033 SHALL cover this scenario: N=1, 16 back-to-back writes -> wr_adr_o 0..15, prod_rdy_o low after the 16th, cons_start_o with bank 0 one cycle later; cons_done_i -> done_o 2 cycles later, blk_cnt_o=1.
REQ-034 SHALL cover this scenario: N=3 with the consumer stalled -> banks 0 and 1 fill (addresses 0..31), prod_rdy_o=0; after cons_done_i bank 0 refills at addresses 0..15.
REQ-035 SHALL cover this scenario: the 16th write of bank 1 coincides with cons_done_i for bank 0 -> both full[1] set and full[0] cleared, then cons_start_o with bank 1 two cycles later.
REQ-036 SHALL cover this scenario: N=0 start -> done_o one cycle later, no writes accepted; prod_wr_i while idle -> err_o=1, wr_en_o=0.
REQ-037 SHALL cover this scenario: abort_i, then rstn_i low, each mid-run after 5 words -> IDLE, wr_adr_o=0, blk_cnt_o=0, no done_o, and a following N=1 run behaves as in REQ-033.
